// File: rtl/bobing_dice_roller.sv
// Bobing dice roller: a free-running 16-bit Galois LFSR feeds a three-state FSM
// that collects six faces in 1..6 into shadow registers, then publishes them to
// D1..D6 together with a single-cycle dice_valid pulse.
module bobing_dice_roller #(
   parameter logic [15:0] SEED = 16'hACE1
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        roll_req,
   input  logic        seed_load,
   input  logic [15:0] seed_in,
   output logic [2:0]  D1,
   output logic [2:0]  D2,
   output logic [2:0]  D3,
   output logic [2:0]  D4,
   output logic [2:0]  D5,
   output logic [2:0]  D6,
   output logic        dice_valid,
   output logic        busy,
   output logic [7:0]  roll_count
);

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_ROLL,
      ST_DONE
   } state_e;

   state_e           state_q, state_d;
   logic [15:0]      lfsr_q, lfsr_d;
   logic [15:0]      lfsr_step;
   logic [2:0]       idx_q, idx_d;
   logic [5:0][2:0]  shadow_q, shadow_d;
   logic [5:0][2:0]  dice_q, dice_d;
   logic             valid_q, valid_d;
   logic             busy_q, busy_d;
   logic [7:0]       count_q, count_d;
   logic [2:0]       sample;
   logic             sample_ok;

   // LFSR successor; ROLL samples the value produced at the current edge, so a
   // seed loaded in IDLE is first seen through its successor.
   always_comb begin
      lfsr_step = {1'b0, lfsr_q[15:1]} ^ (lfsr_q[0] ? 16'hB400 : 16'h0000);
      sample    = lfsr_step[2:0];
      sample_ok = (sample != 3'd0) && (sample != 3'd7);
   end

   // Next-state, LFSR, shadow collection and publish logic.
   always_comb begin
      state_d  = state_q;
      lfsr_d   = lfsr_step;
      idx_d    = idx_q;
      shadow_d = shadow_q;
      dice_d   = dice_q;
      valid_d  = 1'b0;
      busy_d   = busy_q;
      count_d  = count_q;
      case (state_q)
         ST_IDLE: begin
            if (seed_load) begin
               lfsr_d = (seed_in == '0) ? SEED : seed_in;
            end
            if (roll_req) begin
               state_d = ST_ROLL;
               idx_d   = 3'd1;
               busy_d  = 1'b1;
            end
         end
         ST_ROLL: begin
            if (sample_ok) begin
               for (int unsigned i = 0; i < 6; i++) begin
                  if (idx_q == 3'(i + 1)) begin
                     shadow_d[i] = sample;
                  end
               end
               if (idx_q == 3'd6) begin
                  // Publish includes the die accepted at this very edge.
                  state_d = ST_DONE;
                  dice_d  = shadow_d;
                  valid_d = 1'b1;
                  count_d = count_q + 8'd1;
               end else begin
                  idx_d = idx_q + 3'd1;
               end
            end
         end
         ST_DONE: begin
            state_d = ST_IDLE;
            busy_d  = 1'b0;
         end
         default: begin
            state_d = ST_IDLE;
            busy_d  = 1'b0;
         end
      endcase
   end

   // State and datapath registers with asynchronous active-low reset.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q  <= ST_IDLE;
         lfsr_q   <= SEED;
         idx_q    <= 3'd1;
         shadow_q <= {6{3'd1}};
         dice_q   <= {6{3'd1}};
         valid_q  <= 1'b0;
         busy_q   <= 1'b0;
         count_q  <= '0;
      end else begin
         state_q  <= state_d;
         lfsr_q   <= lfsr_d;
         idx_q    <= idx_d;
         shadow_q <= shadow_d;
         dice_q   <= dice_d;
         valid_q  <= valid_d;
         busy_q   <= busy_d;
         count_q  <= count_d;
      end
   end

   assign D1         = dice_q[0];
   assign D2         = dice_q[1];
   assign D3         = dice_q[2];
   assign D4         = dice_q[3];
   assign D5         = dice_q[4];
   assign D6         = dice_q[5];
   assign dice_valid = valid_q;
   assign busy       = busy_q;
   assign roll_count = count_q;

endmodule

// File: tb/tb_bobing_dice_roller.sv
// Bench for bobing_dice_roller: a transaction-level model collects accepted
// faces in a queue and is compared with the DUT on every falling clock edge;
// directed scenarios add hand-computed literal expectations.
module tb_bobing_dice_roller;

   localparam logic [15:0] SEED = 16'hACE1;
   // First roll after reset with roll_req at the first edge (seed ACE1):
   // samples 0,4,6,7,3,1,4,2 -> faces 4,6,3,1,4,2, valid on the 9th edge.
   localparam logic [17:0] FIRST_DICE = {3'd4, 3'd6, 3'd3, 3'd1, 3'd4, 3'd2};
   localparam logic [17:0] ONES       = {6{3'd1}};

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        roll_req = 1'b0;
   logic        seed_load = 1'b0;
   logic [15:0] seed_in = '0;
   logic [2:0]  D1, D2, D3, D4, D5, D6;
   logic        dice_valid, busy;
   logic [7:0]  roll_count;

   int n_checks = 0;
   int n_fail = 0;
   int n_pulses = 0;

   bobing_dice_roller #(.SEED(SEED)) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .roll_req   (roll_req),
      .seed_load  (seed_load),
      .seed_in    (seed_in),
      .D1         (D1),
      .D2         (D2),
      .D3         (D3),
      .D4         (D4),
      .D5         (D5),
      .D6         (D6),
      .dice_valid (dice_valid),
      .busy       (busy),
      .roll_count (roll_count)
   );

   always #5 clk = ~clk;

   function automatic logic [15:0] lfsr_next(input logic [15:0] v);
      return (v >> 1) ^ (v[0] ? 16'hB400 : 16'h0000);
   endfunction

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: actual %0h required %0h at %0t", name, act, exp, $time);
      end
   endtask

   // ---------------- reference model ----------------
   logic [15:0] m_lfsr = SEED;
   logic [2:0]  m_faces[$];
   bit          m_rolling = 0;
   bit          m_done = 0;
   bit          m_valid = 0;
   bit          m_busy = 0;
   logic [7:0]  m_count = '0;
   logic [17:0] m_dice = ONES;
   logic [2:0]  face;

   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         m_lfsr = SEED; m_faces.delete(); m_rolling = 0; m_done = 0;
         m_valid = 0; m_busy = 0; m_count = '0; m_dice = ONES;
      end else begin
         m_valid = 0;
         if (m_done) begin
            m_lfsr = lfsr_next(m_lfsr);
            m_done = 0;
            m_busy = 0;
         end else if (m_rolling) begin
            m_lfsr = lfsr_next(m_lfsr);
            face = m_lfsr[2:0];
            if (face >= 3'd1 && face <= 3'd6) m_faces.push_back(face);
            if (m_faces.size() == 6) begin
               m_dice = {m_faces[0], m_faces[1], m_faces[2], m_faces[3], m_faces[4], m_faces[5]};
               m_valid = 1;
               m_count = m_count + 8'd1;
               m_rolling = 0;
               m_done = 1;
            end
         end else begin
            if (seed_load) m_lfsr = (seed_in == 16'h0) ? SEED : seed_in;
            else           m_lfsr = lfsr_next(m_lfsr);
            if (roll_req) begin
               m_rolling = 1;
               m_busy = 1;
               m_faces.delete();
            end
         end
      end
   end

   // ---------------- per-cycle compare ----------------
   logic [17:0] prev_dice = ONES;
   logic        prev_valid = 1'b0;
   logic        prev_rst = 1'b0;
   logic [17:0] cur_dice;
   logic        range_ok;

   always @(negedge clk) begin
      cur_dice = {D1, D2, D3, D4, D5, D6};
      check("model_dice", cur_dice, m_dice);
      check("model_valid", dice_valid, m_valid);
      check("model_busy", busy, m_busy);
      check("model_count", roll_count, m_count);
      range_ok = 1'b1;
      for (int i = 0; i < 6; i++) begin
         if (cur_dice[3*i +: 3] < 3'd1 || cur_dice[3*i +: 3] > 3'd6) range_ok = 1'b0;
      end
      check("die_range", range_ok, 1'b1);
      check("valid_adjacent", prev_valid & dice_valid, 1'b0);
      if (rst_n && prev_rst)
         check("dice_hold", (cur_dice != prev_dice) && !dice_valid, 1'b0);
      if (dice_valid) n_pulses++;
      prev_dice  = cur_dice;
      prev_valid = dice_valid;
      prev_rst   = rst_n;
   end

   // ---------------- stimulus helpers ----------------
   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic wait_valid(input int budget, output int n);
      n = 0;
      forever begin
         @(negedge clk);
         n++;
         if (dice_valid) return;
         if (n >= budget) begin
            check("wait_valid_timeout", 1'b0, 1'b1);
            return;
         end
      end
   endtask

   int n;
   int base;
   int cyc;

   initial begin
      // Reset state
      repeat (2) step();
      check("reset_dice", {D1, D2, D3, D4, D5, D6}, ONES);
      check("reset_busy", busy, 1'b0);
      check("reset_valid", dice_valid, 1'b0);
      check("reset_count", roll_count, 8'd0);

      // First roll after reset: deterministic literal result
      rst_n = 1'b1;
      roll_req = 1'b1;
      step();
      roll_req = 1'b0;
      wait_valid(40, n);
      check("first_latency", n, 9);
      check("first_dice", {D1, D2, D3, D4, D5, D6}, FIRST_DICE);
      check("first_count", roll_count, 8'd1);
      repeat (3) step();
      check("first_idle_busy", busy, 1'b0);

      // roll_req pulses and seed_load during ROLL are ignored
      base = n_pulses;
      roll_req = 1'b1; step();
      roll_req = 1'b0; step();
      roll_req = 1'b1; step();
      roll_req = 1'b0; seed_load = 1'b1; seed_in = 16'h1234; step();
      roll_req = 1'b1; seed_load = 1'b0; seed_in = '0; step();
      roll_req = 1'b0; step();
      roll_req = 1'b1; step();
      roll_req = 1'b0;
      repeat (60) step();
      check("ignore_pulses", n_pulses - base, 1);
      check("ignore_count", roll_count, 8'd2);

      // Reload with seed_in==0 reproduces the post-reset roll
      seed_load = 1'b1; seed_in = '0; step();
      seed_load = 1'b0; roll_req = 1'b1; step();
      roll_req = 1'b0;
      wait_valid(40, n);
      check("reload_latency", n, 9);
      check("reload_dice", {D1, D2, D3, D4, D5, D6}, FIRST_DICE);
      check("reload_count", roll_count, 8'd3);
      repeat (3) step();

      // Load and roll on the same edge with an explicit seed
      seed_load = 1'b1; seed_in = 16'h1357; roll_req = 1'b1; step();
      seed_load = 1'b0; seed_in = '0; roll_req = 1'b0;
      wait_valid(60, n);
      check("loadroll_count", roll_count, 8'd4);
      repeat (3) step();

      // Reset at the third ROLL edge abandons the roll
      roll_req = 1'b1; step();
      roll_req = 1'b0; step();
      step();
      @(posedge clk);
      #3 rst_n = 1'b0;
      #1;
      check("midreset_dice", {D1, D2, D3, D4, D5, D6}, ONES);
      check("midreset_busy", busy, 1'b0);
      check("midreset_valid", dice_valid, 1'b0);
      check("midreset_count", roll_count, 8'd0);
      repeat (2) step();
      rst_n = 1'b1;
      roll_req = 1'b1;
      step();
      roll_req = 1'b0;
      wait_valid(40, n);
      check("postreset_latency", n, 9);
      check("postreset_dice", {D1, D2, D3, D4, D5, D6}, FIRST_DICE);
      check("postreset_count", roll_count, 8'd1);
      repeat (3) step();

      // Back-to-back stream of 255 rolls wraps roll_count 1 -> 0
      base = n_pulses;
      roll_req = 1'b1;
      cyc = 0;
      while ((n_pulses - base) < 255 && cyc < 255 * 40) begin
         step();
         cyc++;
      end
      roll_req = 1'b0;
      check("stream_pulses", n_pulses - base, 255);
      check("stream_wrap_count", roll_count, 8'd0);
      repeat (20) step();
      check("stream_idle_busy", busy, 1'b0);
      check("stream_final_count", roll_count, 8'd0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
